// File: rtl/sram_pkg.sv
// Shared SRAM definitions: default geometry, read latency and request-type encoding
// for the request controller and its response FIFO.
package sram_pkg;

  localparam int SRAM_DWIDTH = 32;
  localparam int SRAM_AWIDTH = 8;
  localparam int SRAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_WR,
    REQ_RD
  } req_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding SRAM read data until the consumer takes it.
// Head entry is always presented on data_o; pop is ignored when empty.
module sram_rsp_fifo #(
  parameter int DEPTH  = 3,
  parameter int DWIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              pop_i,
  output logic [DWIDTH-1:0] data_o,
  output logic [CW-1:0]     count_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop;

  assign pop = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push_i) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sram_req_ctrl.sv
// Arbitrates write and read request streams onto one single-port SRAM and returns
// read data on a backpressured response stream, gated by occupancy credits.
module sram_req_ctrl
  import sram_pkg::*;
#(
  parameter int DWIDTH    = SRAM_DWIDTH,
  parameter int AWIDTH    = SRAM_AWIDTH,
  parameter int RSP_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int OW = $clog2(RSP_DEPTH + 1);

  logic [OW-1:0]          occ_q, occ_d;
  logic                   last_wr_q;
  logic [SRAM_RD_LAT-1:0] rd_pipe_q;
  logic [AWIDTH-1:0]      addr_q;
  logic [DWIDTH-1:0]      wdata_q;
  logic [OW-1:0]          fifo_count;
  logic                   rd_credit, rd_elig, rd_fire, pop;
  req_e                   gnt;

  // Credit comes from registered occupancy only, so rsp_ready never reaches rd_ready.
  assign rd_credit = occ_q < OW'(RSP_DEPTH);
  assign rd_elig   = rd_valid && rd_credit;

  always_comb begin
    gnt = REQ_NONE;
    if (!rst) begin
      if (wr_valid && rd_elig) gnt = last_wr_q ? REQ_RD : REQ_WR;
      else if (wr_valid)       gnt = REQ_WR;
      else if (rd_elig)        gnt = REQ_RD;
    end
  end

  assign wr_ready = (gnt == REQ_WR);
  assign rd_ready = (gnt == REQ_RD);
  assign rd_fire  = rd_ready;
  assign mem_we   = wr_ready;

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    case (gnt)
      REQ_WR: begin
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
      REQ_RD:  mem_addr = rd_addr;
      default: ;
    endcase
  end

  assign pop   = rsp_valid && rsp_ready;
  assign occ_d = occ_q + OW'(rd_fire) - OW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q     <= '0;
      last_wr_q <= 1'b0;
      rd_pipe_q <= '0;
    end else begin
      occ_q     <= occ_d;
      rd_pipe_q <= (rd_pipe_q << 1) | SRAM_RD_LAT'(rd_fire);
      if (gnt != REQ_NONE) last_wr_q <= (gnt == REQ_WR);
    end
  end

  // Idle cycles replay the last address/data to keep the SRAM pins quiet.
  always_ff @(posedge clk) begin
    addr_q  <= mem_addr;
    wdata_q <= mem_wdata;
  end

  sram_rsp_fifo #(
    .DEPTH  (RSP_DEPTH),
    .DWIDTH (DWIDTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd_pipe_q[SRAM_RD_LAT-1]),
    .data_i  (mem_rdata),
    .pop_i   (pop),
    .data_o  (rsp_data),
    .count_o (fifo_count)
  );

  assign rsp_valid = (fifo_count != '0);

endmodule
